coin_pulse_gen: RTL
===================

// Module: coin_pulse_gen
// PURPOSE
//  Coin input conditioner between the raw coin sources (keyboard 5/6, joystick
//  coin buttons) and the active-low coin bit of the cabinet switch word I_SW2[5].
//  Debounces the OR'd coin level and queues each accepted press. Replays the
//  queue as fixed-width pulses with a fixed gap, so the game CPU never misses or
//  merges a coin, whatever the press rate. Top level inverts coin_out into I_SW2[5].
// PARAMETERS
//  CLK_HZ       48000000  clk_sys frequency; base for all ms timing
//  DEBOUNCE_MS  5         input must be stable this long to change the debounced level
//  PULSE_MS     100       coin_out high time per coin
//  GAP_MS       100       minimum coin_out low time between coins
//  QUEUE_W      3         pending-coin counter width (max 2**QUEUE_W-1 queued)
//  Derived: X_CYC = (CLK_HZ/1000)*X_MS. 24-bit cycle counter; elaboration error if any X_CYC >= 2**24 or X_CYC == 0.
// PORTS
//  clk_sys   in   1        system clock (48 MHz)
//  reset     in   1        synchronous, active-high
//  coin_in   in   1        raw coin level, active-high, may bounce
//  hold      in   1        1 = do not start new pulses (tie to pause_cpu)
//  coin_out  out  1        conditioned coin pulse, active-high
//  busy      out  1        1 while FSM is not IDLE
//  pending   out  QUEUE_W  coins accepted but not yet issued
//  overflow  out  1        sticky: a press was dropped because the queue was full
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; sync flops, debounced level, counters = 0.
//   Reset mid-pulse drops coin_out on the next edge and discards the queue.
//  Input path: 2-flop synchronizer (s1, s2). deb_cnt counts consecutive cycles with s2 != deb_lvl.
//   When deb_cnt reaches DEBOUNCE_CYC-1 with s2 still differing, deb_lvl <= s2 and deb_cnt <= 0.
//   Any cycle with s2 == deb_lvl clears deb_cnt.
//  Accept: a rising edge of deb_lvl (registered one cycle later as acc) increments pending.
//   If pending is all-ones, the increment is dropped and overflow is set.
//  FSM (state counter cnt, 24 bit, cleared on every state entry):
//   IDLE : if pending!=0 && !hold -> PULSE, pending-1, coin_out<=1.
//   PULSE: coin_out=1; when cnt==PULSE_CYC-1 -> GAP, coin_out<=0.
//   GAP  : coin_out=0; when cnt==GAP_CYC-1 -> IDLE.
//   coin_out is a register; its high time is exactly PULSE_CYC cycles.
//   Back-to-back coins give a low time of exactly GAP_CYC+1 cycles (GAP plus one IDLE cycle).
//  Simultaneous accept and FSM decrement in the same cycle: pending is unchanged, no overflow.
//  Full queue with a simultaneous decrement: the accept is taken, no overflow.
//  hold only gates IDLE->PULSE. A pulse or gap already in progress always completes.
//   Accepts still queue while hold=1.
//  Latency: coin_in 0->1, stable, first sampled at edge E -> coin_out rises at edge E+DEBOUNCE_CYC+3.
//  Release is debounced the same way. Press length does not matter beyond DEBOUNCE_CYC.
//  busy = (state != IDLE). pending wraps never (saturates).
// TESTING (CLK_HZ=1000 so 1 cycle = 1 ms; DEBOUNCE=5, PULSE=4, GAP=3, QUEUE_W=3)
//  1. coin_in high 20 cycles -> coin_out high at E+8 for exactly 4 cycles; pending 1 then 0; busy high 7 cycles.
//  2. coin_in toggling every 2 cycles for 30 cycles, then low -> no accept, coin_out stays 0, pending 0.
//  3. 3 clean presses (6 high/6 low) -> 3 pulses of 4 cycles, gaps of 4 cycles; pending peaks at 2 or less.
//  4. 9 clean presses during hold=1 -> pending saturates at 7, overflow=1; hold=0 -> 7 pulses, overflow stays 1.
//  5. reset asserted 2 cycles into PULSE with pending=3 -> next edge: coin_out=0, pending=0, busy=0, overflow=0.
//  6. accept on the same cycle as IDLE->PULSE with pending=1 -> pending stays 1; a second pulse follows after the gap.

Source files
------------

// File: rtl/coin_pulse_gen.sv
// coin_pulse_gen: debounces a raw coin level, queues accepted presses and replays them as fixed pulses
// Ports:
//   clk_sys  - system clock, base for all ms timing
//   reset    - synchronous, active-high
//   coin_in  - raw coin level, active-high, may bounce
//   hold     - 1 blocks the start of new pulses (running pulse/gap still completes)
//   coin_out - conditioned coin pulse, active-high, registered
//   busy     - 1 while the pulse FSM is not IDLE
//   pending  - coins accepted but not yet issued (saturating)
//   overflow - sticky, a press was dropped because the queue was full
module coin_pulse_gen #(
  parameter int CLK_HZ      = 48000000,
  parameter int DEBOUNCE_MS = 5,
  parameter int PULSE_MS    = 100,
  parameter int GAP_MS      = 100,
  parameter int QUEUE_W     = 3
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               coin_in,
  input  logic               hold,
  output logic               coin_out,
  output logic               busy,
  output logic [QUEUE_W-1:0] pending,
  output logic               overflow
);
  localparam int DEB_CYC   = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int PULSE_CYC = (CLK_HZ / 1000) * PULSE_MS;
  localparam int GAP_CYC   = (CLK_HZ / 1000) * GAP_MS;
  if (DEB_CYC <= 0 || DEB_CYC >= 2**24 || PULSE_CYC <= 0 || PULSE_CYC >= 2**24 ||
      GAP_CYC <= 0 || GAP_CYC >= 2**24) begin : g_bad_timing
    $error("coin_pulse_gen: derived cycle count must be in 1..2**24-1");
  end
  localparam logic [23:0] DEB_END   = 24'(DEB_CYC - 1);
  localparam logic [23:0] PULSE_END = 24'(PULSE_CYC - 1);
  localparam logic [23:0] GAP_END   = 24'(GAP_CYC - 1);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t      state, state_n;
  logic        s1, s2, deb_lvl, deb_d, acc, dec, coin_n, clr;
  logic [23:0] deb_cnt, cnt;
  // one-cycle strobe on the rising edge of the debounced level
  assign acc  = deb_lvl & ~deb_d;
  assign busy = state != IDLE;
  // counter restarts on every state entry and is held at zero while idle
  assign clr  = state_n != state || state == IDLE;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      deb_lvl  <= 1'b0;
      deb_d    <= 1'b0;
      deb_cnt  <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      s1    <= coin_in;
      s2    <= s1;
      deb_d <= deb_lvl;
      if (s2 == deb_lvl) deb_cnt <= '0;
      else if (deb_cnt == DEB_END) begin
        deb_lvl <= s2;
        deb_cnt <= '0;
      end else deb_cnt <= deb_cnt + 24'd1;
      // an accept coinciding with an issue nets to no change, even when full
      if (acc && !dec && &pending) overflow <= 1'b1;
      else if (acc && !dec) pending <= pending + 1'b1;
      else if (!acc && dec) pending <= pending - 1'b1;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      coin_out <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      coin_out <= coin_n;
      cnt      <= clr ? '0 : cnt + 24'd1;
    end
  end
  always_comb begin
    state_n = state;
    coin_n  = coin_out;
    dec     = 1'b0;
    case (state)
      IDLE: if (|pending && !hold) begin
        state_n = PULSE;
        coin_n  = 1'b1;
        dec     = 1'b1;
      end
      PULSE: if (cnt == PULSE_END) begin
        state_n = GAP;
        coin_n  = 1'b0;
      end
      GAP: if (cnt == GAP_END) state_n = IDLE;
      default: begin
        state_n = IDLE;
        coin_n  = 1'b0;
      end
    endcase
  end
endmodule
